// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC scalar front end: signed-digit encodings and
// the recoder FSM state type.
package ecc_pkg;

    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_POS  = 2'b01;
    localparam logic [1:0] DIG_NEG  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } naf_state_t;

endpackage

// File: rtl/naf_digit_step.sv
// One NAF recoding step: from the remaining scalar, the next signed digit,
// the remaining scalar after that digit, and whether it is the final digit.
module naf_digit_step
    import ecc_pkg::*;
#(
    parameter int n = 231
) (
    input  logic [n:0] i_kreg,
    output logic [1:0] o_digit,
    output logic [n:0] o_next_k,
    output logic       o_last
);

    logic [n:0] w_adj;

    // k mod 4 == 3 takes -1 (adding 1 clears the next bit), k mod 4 == 1 takes +1
    always_comb begin
        o_digit = DIG_ZERO;
        w_adj   = i_kreg;
        if (i_kreg[0]) begin
            if (i_kreg[1]) begin
                o_digit = DIG_NEG;
                w_adj   = i_kreg + (n+1)'(1);
            end else begin
                o_digit = DIG_POS;
                w_adj   = i_kreg - (n+1)'(1);
            end
        end
        o_next_k = w_adj >> 1;
        o_last   = (o_next_k == '0);
    end

endmodule

// File: rtl/scalar_naf_recoder.sv
// Streams the NAF of an n-bit scalar LSB-first over a valid/ready handshake.
// NAF_WEIGHT_STATS_EN: when defined, o_nz_count counts accepted non-zero digits.
module scalar_naf_recoder
    import ecc_pkg::*;
#(
    parameter int n = 231
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_start,
    input  logic [n-1:0]              i_k,
    output logic                      o_busy,
    output logic                      o_digit_valid,
    input  logic                      i_digit_ready,
    output logic [1:0]                o_digit,
    output logic                      o_digit_last,
    output logic [$clog2(n+2)-1:0]    o_digit_count,
    output logic                      o_done,
    output logic [$clog2(n+2)-1:0]    o_nz_count
);

    localparam int CW = $clog2(n+2);

    naf_state_t  r_state;
    naf_state_t  w_state_nxt;
    logic [n:0]  r_kreg;
    logic [CW-1:0] r_digit_count;
    logic        r_done;
    logic [1:0]  w_digit;
    logic [n:0]  w_next_k;
    logic        w_last;
    logic        w_hs;

    naf_digit_step #(.n(n)) u_step (
        .i_kreg   (r_kreg),
        .o_digit  (w_digit),
        .o_next_k (w_next_k),
        .o_last   (w_last)
    );

    assign o_digit_valid = (r_state == EMIT);
    assign w_hs          = o_digit_valid & i_digit_ready;
    assign o_digit       = o_digit_valid ? w_digit : DIG_ZERO;
    assign o_digit_last  = o_digit_valid & w_last;
    assign o_busy        = (r_state != IDLE);
    assign o_done        = r_done;
    assign o_digit_count = r_digit_count;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = (r_kreg == '0) ? IDLE : EMIT;
            EMIT:    if (w_hs && w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // kreg carries one spare MSB so the final +1 carry of an all-ones scalar survives
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kreg        <= '0;
            r_digit_count <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE && i_start) begin
                r_kreg        <= {1'b0, i_k};
                r_digit_count <= '0;
            end
            if (r_state == LOAD && r_kreg == '0)
                r_done <= 1'b1;
            if (w_hs) begin
                r_kreg        <= w_next_k;
                r_digit_count <= r_digit_count + CW'(1);
                if (w_last) r_done <= 1'b1;
            end
        end
    end

`ifdef NAF_WEIGHT_STATS_EN
    logic [CW-1:0] r_nz_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_nz_count <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_nz_count <= '0;
        end else if (w_hs && w_digit != DIG_ZERO) begin
            r_nz_count <= r_nz_count + CW'(1);
        end
    end

    assign o_nz_count = r_nz_count;
`else
    assign o_nz_count = '0;
`endif

endmodule

// File: tb/tb_scalar_naf_recoder.sv
// Directed and randomised checks of scalar_naf_recoder at n=8 and n=231.
module tb_scalar_naf_recoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         s8_start = 1'b0;
    logic [7:0]   s8_k = '0;
    logic         s8_ready = 1'b0;
    logic         s8_busy, s8_valid, s8_last, s8_done;
    logic [1:0]   s8_digit;
    logic [3:0]   s8_cnt, s8_nz;

    logic         s2_start = 1'b0;
    logic [230:0] s2_k = '0;
    logic         s2_ready = 1'b0;
    logic         s2_busy, s2_valid, s2_last, s2_done;
    logic [1:0]   s2_digit;
    logic [7:0]   s2_cnt, s2_nz;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] exp_d [0:15];
    int         exp_len;

    scalar_naf_recoder #(.n(8)) u8 (
        .clk(clk), .reset(reset), .i_start(s8_start), .i_k(s8_k),
        .o_busy(s8_busy), .o_digit_valid(s8_valid), .i_digit_ready(s8_ready),
        .o_digit(s8_digit), .o_digit_last(s8_last), .o_digit_count(s8_cnt),
        .o_done(s8_done), .o_nz_count(s8_nz)
    );

    scalar_naf_recoder #(.n(231)) u231 (
        .clk(clk), .reset(reset), .i_start(s2_start), .i_k(s2_k),
        .o_busy(s2_busy), .o_digit_valid(s2_valid), .i_digit_ready(s2_ready),
        .o_digit(s2_digit), .o_digit_last(s2_last), .o_digit_count(s2_cnt),
        .o_done(s2_done), .o_nz_count(s2_nz)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one n=8 scalar against exp_d/exp_len; optional stall and ignored start injection.
    task automatic run8(input string tag, input logic [7:0] k, input int stall_at,
                        input int stall_len, input int inj_at, input logic [7:0] inj_k);
        int hs = 0, first = -1, stalled = 0, exp_nz = 0;
        bit inj = 0, fin = 0;
        for (int i = 0; i < exp_len; i++) if (exp_d[i] != 2'b00) exp_nz++;
        @(negedge clk);
        s8_start = 1'b1; s8_k = k; s8_ready = 1'b1;
        for (int idx = 1; idx <= 60 && !fin; idx++) begin
            @(negedge clk);
            if (s8_done) begin
                fin = 1;
            end else begin
                if (s8_valid && first < 0) first = idx;
                if (hs == stall_at && stalled < stall_len) begin
                    s8_ready = 1'b0;
                    stalled++;
                    check({tag, "_stall_valid"}, s8_valid, 1'b1);
                    if (hs < 16) check({tag, "_stall_digit"}, s8_digit, exp_d[hs]);
                end else begin
                    s8_ready = 1'b1;
                end
                if (hs == inj_at && !inj) begin
                    s8_start = 1'b1; s8_k = inj_k; inj = 1;
                end else begin
                    s8_start = 1'b0;
                end
                if (s8_valid && s8_ready) begin
                    if (hs < 16) check({tag, "_digit"}, s8_digit, exp_d[hs]);
                    check({tag, "_last"}, s8_last, (hs == exp_len - 1));
                    hs++;
                end
            end
        end
        s8_start = 1'b0;
        check({tag, "_done_seen"}, fin, 1'b1);
        check({tag, "_ndigits"}, hs, exp_len);
        check({tag, "_latency"}, first, 2);
        check({tag, "_count"}, s8_cnt, exp_len);
        check({tag, "_busy_at_done"}, s8_busy, 1'b0);
`ifdef NAF_WEIGHT_STATS_EN
        check({tag, "_nz"}, s8_nz, exp_nz);
`else
        check({tag, "_nz"}, s8_nz, 0);
`endif
        @(negedge clk);
        check({tag, "_done_single"}, s8_done, 1'b0);
    endtask

    // Reconstructs sum(d_i*2^i) from an n=231 stream under random backpressure.
    task automatic run231(input string tag, input logic [230:0] k);
        logic [232:0] acc = '0;
        logic [232:0] bit_i;
        int hs = 0, adj = 0, bad = 0, nzc = 0, last_at = -1;
        bit prev_nz = 0, fin = 0, nz;
        @(negedge clk);
        s2_start = 1'b1; s2_k = k;
        for (int idx = 1; idx <= 2000 && !fin; idx++) begin
            @(negedge clk);
            s2_start = 1'b0;
            if (s2_done) begin
                fin = 1;
            end else begin
                s2_ready = ($urandom_range(0, 3) != 0);
                if (s2_valid && s2_ready) begin
                    bit_i = 233'(1) << hs;
                    case (s2_digit)
                        2'b01:   acc = acc + bit_i;
                        2'b11:   acc = acc - bit_i;
                        2'b00:   ;
                        default: bad++;
                    endcase
                    nz = (s2_digit != 2'b00);
                    if (nz) nzc++;
                    if (nz && prev_nz) adj++;
                    prev_nz = nz;
                    if (s2_last) last_at = hs;
                    hs++;
                end
            end
        end
        check({tag, "_done_seen"}, fin, 1'b1);
        check({tag, "_sum"}, acc, {2'b00, k});
        check({tag, "_adjacent"}, adj, 0);
        check({tag, "_bad_code"}, bad, 0);
        check({tag, "_last_pos"}, last_at, hs - 1);
        check({tag, "_max_len"}, (hs <= 232), 1'b1);
        check({tag, "_count"}, s2_cnt, hs);
`ifdef NAF_WEIGHT_STATS_EN
        check({tag, "_nz"}, s2_nz, nzc);
`else
        check({tag, "_nz"}, s2_nz, 0);
`endif
    endtask

    initial begin
        logic [255:0] r;

        repeat (3) @(negedge clk);
        check("rst_busy", s8_busy, 1'b0);
        check("rst_valid", s8_valid, 1'b0);
        check("rst_digit", s8_digit, 2'b00);
        check("rst_last", s8_last, 1'b0);
        check("rst_done", s8_done, 1'b0);
        check("rst_count", s8_cnt, 0);
        check("rst_nz", s8_nz, 0);
        check("rst_busy231", s2_busy, 1'b0);
        reset = 1'b0;

        exp_len = 4;
        exp_d[0] = 2'b11; exp_d[1] = 2'b00; exp_d[2] = 2'b00; exp_d[3] = 2'b01;
        run8("k7", 8'd7, -1, 0, -1, 8'd0);

        exp_len = 9;
        exp_d[0] = 2'b11;
        for (int i = 1; i < 8; i++) exp_d[i] = 2'b00;
        exp_d[8] = 2'b01;
        run8("k255", 8'd255, -1, 0, -1, 8'd0);

        @(negedge clk);
        s8_start = 1'b1; s8_k = 8'd0;
        @(negedge clk);
        s8_start = 1'b0;
        check("k0_busy_load", s8_busy, 1'b1);
        check("k0_done_early", s8_done, 1'b0);
        check("k0_valid1", s8_valid, 1'b0);
        @(negedge clk);
        check("k0_done", s8_done, 1'b1);
        check("k0_valid2", s8_valid, 1'b0);
        check("k0_count", s8_cnt, 0);
        @(negedge clk);
        check("k0_done_single", s8_done, 1'b0);

        exp_len = 3;
        exp_d[0] = 2'b01; exp_d[1] = 2'b00; exp_d[2] = 2'b01;
        run8("k5_stall", 8'd5, 1, 3, -1, 8'd0);

        exp_len = 4;
        exp_d[0] = 2'b11; exp_d[1] = 2'b00; exp_d[2] = 2'b00; exp_d[3] = 2'b01;
        run8("k7_inj", 8'd7, -1, 0, 1, 8'd5);

        @(negedge clk);
        s8_start = 1'b1; s8_k = 8'd255; s8_ready = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_busy", s8_busy, 1'b0);
        check("rstmid_valid", s8_valid, 1'b0);
        check("rstmid_digit", s8_digit, 2'b00);
        check("rstmid_last", s8_last, 1'b0);
        check("rstmid_count", s8_cnt, 0);
        check("rstmid_nz", s8_nz, 0);
        check("rstmid_done", s8_done, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_done2", s8_done, 1'b0);
        check("rstmid_busy2", s8_busy, 1'b0);

        exp_len = 9;
        exp_d[0] = 2'b11;
        for (int i = 1; i < 8; i++) exp_d[i] = 2'b00;
        exp_d[8] = 2'b01;
        run8("after_rst", 8'd255, -1, 0, -1, 8'd0);

        run231("ones231", {231{1'b1}});
        run231("one231", 231'd1);
        run231("msb231", 231'd1 << 230);
        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
            run231($sformatf("rnd%0d", t), r[230:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
